// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// access-size encodings, byte-lane mask and load extension.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Byte lanes touched by an access of the given size at the given byte offset.
    function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SIZE_B:  mask = 4'b0001 << offset;
            SIZE_H:  mask = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Move the addressed lane(s) of a word down to the LSBs and extend to 32 bits.
    function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] offset, input logic isUnsigned);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        result  = 32'h0;
        case (size)
            SIZE_B:  result = isUnsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  result = isUnsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_W:  result = word;
            default: result = 32'h0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word-organised storage with per-byte write enables; contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];

    // Synchronous write of only the enabled byte lanes; other lanes keep their value.
    always_ff @(posedge clk_i) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (we_i[lane]) begin
                mem[waddr_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
            end
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder: accepts one request, waits LATENCY
// cycles, commits the store or captures the load result, then holds the
// response until the datapath consumes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    state_e          state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic            write_q, unsigned_q, err_q;
    logic [1:0]      size_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     respRdata_q, respRdata_d;
    logic            respErr_q, respErr_d;

    logic            accept, enterResp, reqErr;
    logic            curWrite, curUnsigned, curErr;
    logic [1:0]      curSize;
    logic [AW+1:0]   curAddr;
    logic [31:0]     curWdata;
    logic [3:0]      memWe;
    logic [31:0]     memWdata, memRdata;

    assign accept = req_valid_i && (state_q == IDLE);

    // Classify the incoming request: misaligned, illegal size or beyond the storage.
    always_comb begin
        reqErr = (req_size_i == 2'd3)
              || ((req_size_i == SIZE_H) && req_addr_i[0])
              || ((req_size_i == SIZE_W) && (req_addr_i[1:0] != 2'b00))
              || ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS));
    end

    // In IDLE the live request is used so that LATENCY = 1 can commit on the accept edge.
    always_comb begin
        if (state_q == IDLE) begin
            curWrite    = req_write_i;
            curUnsigned = req_unsigned_i;
            curErr      = reqErr;
            curSize     = req_size_i;
            curAddr     = req_addr_i[AW+1:0];
            curWdata    = req_wdata_i;
        end else begin
            curWrite    = write_q;
            curUnsigned = unsigned_q;
            curErr      = err_q;
            curSize     = size_q;
            curAddr     = addr_q;
            curWdata    = wdata_q;
        end
    end

    // State and latency-counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: IDLE -> WAIT (or RESP at latency 1) -> RESP -> IDLE.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        enterResp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        enterResp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        count_d = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (count_q == 4'd0) begin
                    state_d   = RESP;
                    enterResp = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture every request field on the accepting edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= SIZE_B;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
        end else if (accept) begin
            write_q    <= req_write_i;
            unsigned_q <= req_unsigned_i;
            err_q      <= reqErr;
            size_q     <= req_size_i;
            addr_q     <= req_addr_i[AW+1:0];
            wdata_q    <= req_wdata_i;
        end
    end

    // Store commit and lane replication happen only on the edge that enters RESP.
    always_comb begin
        memWe = (enterResp && curWrite && !curErr) ? laneMask(curSize, curAddr[1:0]) : 4'b0000;
        case (curSize)
            SIZE_B:  memWdata = {4{curWdata[7:0]}};
            SIZE_H:  memWdata = {2{curWdata[15:0]}};
            default: memWdata = curWdata;
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (memWe),
        .waddr_i (curAddr[AW+1:2]),
        .wdata_i (memWdata),
        .raddr_i (curAddr[AW+1:2]),
        .rdata_o (memRdata)
    );

    // Response payload is latched on entry to RESP and held until consumed.
    always_comb begin
        respRdata_d = respRdata_q;
        respErr_d   = respErr_q;
        if (enterResp) begin
            respErr_d   = curErr;
            respRdata_d = (curErr || curWrite) ? 32'h0
                        : loadExtend(memRdata, curSize, curAddr[1:0], curUnsigned);
        end
    end

    // Response payload register, cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            respRdata_q <= 32'h0;
            respErr_q   <= 1'b0;
        end else begin
            respRdata_q <= respRdata_d;
            respErr_q   <= respErr_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = respRdata_q;
    assign resp_err_o   = respErr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a memory/latency reference model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst;
    logic        reqValid, reqReady, reqWrite, reqUnsigned;
    logic [31:0] reqAddr, reqWdata;
    logic [1:0]  reqSize;
    logic        respValid, respReady, respErr;
    logic [31:0] respRdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] modelMem [0:DEPTH-1];
    logic        expReady, expValid, expZero, expErr;
    logic [31:0] expRdata;
    logic        checkEn;

    logic        litValid, litErr;
    logic [31:0] litRdata;
    string       litName;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (reqValid),
        .req_ready_o    (reqReady),
        .req_write_i    (reqWrite),
        .req_addr_i     (reqAddr),
        .req_wdata_i    (reqWdata),
        .req_size_i     (reqSize),
        .req_unsigned_i (reqUnsigned),
        .resp_valid_o   (respValid),
        .resp_ready_i   (respReady),
        .resp_rdata_o   (respRdata),
        .resp_err_o     (respErr)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: count it and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Every falling edge compare the DUT with the model, plus the literal pins when in RESP.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("req_ready", {31'b0, reqReady}, {31'b0, expReady});
            checkOutput("resp_valid", {31'b0, respValid}, {31'b0, expValid});
            if (expValid || expZero) begin
                checkOutput("resp_rdata", respRdata, expValid ? expRdata : 32'h0);
                checkOutput("resp_err", {31'b0, respErr}, {31'b0, expValid ? expErr : 1'b0});
            end
            if (expValid && litValid) begin
                checkOutput({litName, " rdata"}, respRdata, litRdata);
                checkOutput({litName, " err"}, {31'b0, respErr}, {31'b0, litErr});
            end
        end
    end

    // Reference behaviour of one access, applied to the bench's own memory image.
    function automatic void modelAccess(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic u,
                                        output logic [31:0] rd, output logic e);
        int          idx;
        int          sh;
        logic [31:0] word;
        logic [31:0] v;
        e  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
          || (a[31:2] >= 30'(DEPTH));
        rd = 32'h0;
        if (!e) begin
            idx  = int'(a[31:2]);
            sh   = 8 * int'(a[1:0]);
            word = modelMem[idx];
            if (w) begin
                if (sz == 2'd0)      word = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                else if (sz == 2'd1) word = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
                else                 word = wd;
                modelMem[idx] = word;
            end else begin
                if (sz == 2'd0) begin
                    v = (word >> sh) & 32'hFF;
                    if (!u && v[7]) v = v | 32'hFFFFFF00;
                end else if (sz == 2'd1) begin
                    v = (word >> sh) & 32'hFFFF;
                    if (!u && v[15]) v = v | 32'hFFFF0000;
                end else begin
                    v = word;
                end
                rd = v;
            end
        end
    endfunction

    // Issue one request from IDLE, follow it through the latency window and consume the response.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [1:0] sz, input logic u, input int hold,
                                 input logic earlyReady, input string nm,
                                 input logic [31:0] litRd, input logic litE);
        logic [31:0] rd;
        logic        e;
        reqValid    = 1'b1;
        reqWrite    = w;
        reqAddr     = a;
        reqWdata    = wd;
        reqSize     = sz;
        reqUnsigned = u;
        litName     = nm;
        litRdata    = litRd;
        litErr      = litE;
        litValid    = 1'b1;
        @(posedge clk); #1;
        reqValid  = 1'b0;
        respReady = earlyReady;
        expReady  = 1'b0;
        expZero   = 1'b0;
        modelAccess(w, a, wd, sz, u, rd, e);
        expRdata  = rd;
        expErr    = e;
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        respReady = 1'b0;
        expValid  = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        respReady = 1'b1;
        @(posedge clk); #1;
        respReady = 1'b0;
        expValid  = 1'b0;
        expReady  = 1'b1;
        litValid  = 1'b0;
    endtask

    // Start a store and hit reset while it is still waiting; the store must vanish.
    task automatic applyAbort(input logic [31:0] a, input logic [31:0] wd);
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = a;
        reqWdata = wd;
        reqSize  = 2'd2;
        @(posedge clk); #1;
        reqValid = 1'b0;
        rst      = 1'b1;
        expReady = 1'b1;
        expValid = 1'b0;
        expZero  = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Main directed sequence.
    initial begin
        rst         = 1'b1;
        reqValid    = 1'b0;
        reqWrite    = 1'b0;
        reqAddr     = 32'h0;
        reqWdata    = 32'h0;
        reqSize     = 2'd0;
        reqUnsigned = 1'b0;
        respReady   = 1'b0;
        checkEn     = 1'b0;
        expReady    = 1'b1;
        expValid    = 1'b0;
        expZero     = 1'b1;
        expErr      = 1'b0;
        expRdata    = 32'h0;
        litValid    = 1'b0;
        litErr      = 1'b0;
        litRdata    = 32'h0;
        litName     = "";
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'h0;

        repeat (2) @(posedge clk);
        #1 checkEn = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b1, "sw 0x10",  32'h0,        1'b0);
        applyStimulus(1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 0, 1'b0, "lw 0x10",  32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 32'h13,  32'h0,        2'd0, 1'b0, 0, 1'b0, "lb 0x13",  32'hFFFFFFDE, 1'b0);
        applyStimulus(1'b0, 32'h13,  32'h0,        2'd0, 1'b1, 0, 1'b0, "lbu 0x13", 32'h000000DE, 1'b0);
        applyStimulus(1'b0, 32'h12,  32'h0,        2'd1, 1'b0, 0, 1'b0, "lh 0x12",  32'hFFFFDEAD, 1'b0);
        applyStimulus(1'b0, 32'h10,  32'h0,        2'd1, 1'b1, 0, 1'b0, "lhu 0x10", 32'h0000BEEF, 1'b0);
        applyStimulus(1'b1, 32'h11,  32'h00000055, 2'd0, 1'b0, 0, 1'b0, "sb 0x11",  32'h0,        1'b0);
        applyStimulus(1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 0, 1'b0, "lw 0x10b", 32'hDEAD55EF, 1'b0);
        applyStimulus(1'b0, 32'h11,  32'h0,        2'd1, 1'b0, 0, 1'b0, "lh 0x11",  32'h0,        1'b1);
        applyStimulus(1'b1, 32'h0,   32'hCAFEF00D, 2'd2, 1'b0, 0, 1'b0, "sw 0x0",   32'h0,        1'b0);
        applyStimulus(1'b1, 32'h400, 32'h11111111, 2'd2, 1'b0, 0, 1'b0, "sw 0x400", 32'h0,        1'b1);
        applyStimulus(1'b0, 32'h0,   32'h0,        2'd2, 1'b1, 0, 1'b0, "lw 0x0",   32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, 32'h0,   32'h0,        2'd3, 1'b0, 0, 1'b0, "size3",    32'h0,        1'b1);
        applyStimulus(1'b1, 32'h20,  32'h0,        2'd2, 1'b0, 0, 1'b0, "sw 0x20",  32'h0,        1'b0);
        applyStimulus(1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 5, 1'b0, "backpres", 32'hDEAD55EF, 1'b0);
        applyAbort(32'h20, 32'h12345678);
        applyStimulus(1'b0, 32'h20,  32'h0,        2'd2, 1'b0, 0, 1'b0, "lw 0x20",  32'h0,        1'b0);

        repeat (3) @(posedge clk);
        #1 checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit words of storage; it is a power of two, 2..65536.
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from request acceptance to response-valid; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  reset; asynchronous assert, active-high.
REQ-005 req_valid  input  1  M-stage load/store request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (LSBs).
REQ-010 req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-011 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  datapath consumes the response.
REQ-014 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 resp_err  output  1  request was misaligned, out of range, or had an illegal size.

Function
REQ-016 The state machine SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a posedge where req_valid && req_ready; all req_* fields SHALL be captured on that edge.
REQ-018 After acceptance, IDLE SHALL go to WAIT with counter = LATENCY-1, or directly to RESP when LATENCY = 1.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0, so resp_valid rises exactly LATENCY edges after the accepting edge.
REQ-020 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until the posedge with resp_ready = 1, then return to IDLE.
REQ-021 Accepting a new request SHALL require returning to IDLE first, so back-to-back requests are spaced by at least LATENCY+1 cycles.
REQ-022 An error SHALL be flagged when any of these holds: size 1 with addr[0] != 0; size 2 with addr[1:0] != 0; size 3; or word index addr[31:2] >= DEPTH_WORDS.
REQ-023 An erroring request SHALL still complete the handshake with resp_err = 1, resp_rdata = 0 and no storage write.
REQ-024 A store SHALL write only the addressed byte lanes, on the edge that enters RESP:
- byte: lane addr[1:0];
- half: lanes addr[1]*2 and addr[1]*2+1;
- word: all four lanes.
Other lanes SHALL be unchanged.
REQ-025 A load SHALL read the word at entry to RESP, shift the addressed lane(s) to the LSBs, and extend per req_unsigned; word loads ignore req_unsigned.
REQ-026 A store followed by a load to the same address SHALL return the stored data; there is no stale-read window.
REQ-027 resp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-028 While rst is 1, and asynchronously on its assertion, the following SHALL hold:
- state = IDLE, counter = 0;
- req_ready = 1 from the first cycle after release;
- resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-029 Reset asserted mid-transaction SHALL drop that transaction; a store not yet committed SHALL NOT write.
REQ-030 Storage contents SHALL NOT be reset.

Structure
REQ-031 A shared package SHALL hold:
- the state enum;
- the size encodings (SIZE_B, SIZE_H, SIZE_W);
- the byte-lane-mask and load-extend functions.
REQ-032 Storage SHALL be one sub-module, dmem_array: a DEPTH_WORDS x 32 array with 4-bit byte-write enables, one synchronous write port and one combinational read port.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Word store then load, LATENCY = 2: store 0xDEADBEEF to 0x10, then load word 0x10 -> resp_valid exactly 2 cycles after each accept, rdata = 0xDEADBEEF, err = 0.
- Byte and half extension: after the above, lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
- Partial store: sb 0x11 with wdata 0x00000055 -> word 0x10 reads 0xDEAD55EF.
- Errors:
  - lh 0x11 -> err = 1, rdata = 0;
  - sw 0x400 with DEPTH 256 -> err = 1 and a following lw 0x0 is unchanged;
  - size 3 -> err = 1.
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready = 0 throughout; IDLE one cycle after resp_ready = 1.
- Reset mid-WAIT: store 0x12345678 to 0x20 over a prior 0x0, assert rst during WAIT -> outputs at reset values, req_ready = 1 after release, lw 0x20 returns 0x0.
